i2c_target: RTL and testbench

I2C target (slave) endpoint that answers a bus initiator at a fixed 7-bit address and exposes an 8-bit register-pointer interface to local logic. It sits on the board I2C pins, parallel to the existing initiator, so an external controller or a loop-back test can read and write a small local register bank. It samples SCL/SDA with the system clock, detects START/STOP/repeated-START, ACKs its own address, and auto-increments the pointer. It supports 7-bit addressing, standard and fast mode, and no clock stretching.

---
 rtl/i2c_target.sv | 241 ++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target at TGT_ADDR with an auto-incrementing 8-bit register pointer; optional SCL/SDA glitch filter under I2C_TARGET_GLITCH_FILTER_EN.
// Latency: 3 CLK pin-to-event (+FILT_LEN when filtered), REG_WE 1 CLK after the internal 8th SCL rise, REG_RDATA sampled 1 CLK after REG_RE.
// Backpressure: none; SCL is never stretched, so local logic must answer REG_RE within one CLK.
module i2c_target #(
  parameter logic [6:0] TGT_ADDR = 7'h50,
  parameter int         FILT_LEN = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  output logic       REG_RE,
  input  logic [7:0] REG_RDATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_WAIT_STOP
  } state_t;

  logic scl_s1, scl_s2, sda_s1, sda_s2;
  logic scl_f, sda_f, scl_d, sda_d;

  // Synchronizers and edge-detect stage reset to the idle-bus level so reset release never looks like a START.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= I2C_SCL;
      scl_s2 <= scl_s1;
      sda_s1 <= I2C_SDA;
      sda_s2 <= sda_s1;
      scl_d  <= scl_f;
      sda_d  <= sda_f;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [CW-1:0] scl_cnt, sda_cnt;

  // A new level is accepted only after FILT_LEN consecutive samples disagree with the current one.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_s2 == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CW'(FILT_LEN - 1)) begin
        scl_f   <= scl_s2;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_s2 == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CW'(FILT_LEN - 1)) begin
        sda_f   <= sda_s2;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_filt_len;
  assign unused_filt_len = ^FILT_LEN;
  assign scl_f = scl_s2;
  assign sda_f = sda_s2;
`endif

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  state_t      state, state_nx;
  logic [3:0]  bit_cnt, bit_cnt_nx;
  logic [7:0]  shreg, shreg_nx, byte_in;
  logic [7:0]  reg_addr_nx, reg_wdata_nx;
  logic        sda_oe, sda_oe_nx;
  logic        reg_we_nx, reg_re_nx, busy_nx;
  logic        rw, rw_nx, mack, mack_nx;

  assign byte_in = {shreg[6:0], sda_f};
  assign I2C_SDA = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      sda_oe    <= 1'b0;
      REG_ADDR  <= '0;
      REG_WDATA <= '0;
      REG_WE    <= 1'b0;
      REG_RE    <= 1'b0;
      BUSY      <= 1'b0;
      rw        <= 1'b0;
      mack      <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      shreg     <= shreg_nx;
      sda_oe    <= sda_oe_nx;
      REG_ADDR  <= reg_addr_nx;
      REG_WDATA <= reg_wdata_nx;
      REG_WE    <= reg_we_nx;
      REG_RE    <= reg_re_nx;
      BUSY      <= busy_nx;
      rw        <= rw_nx;
      mack      <= mack_nx;
    end
  end

  // bit_cnt reaches 8 on the 8th rise and 9 on the ACK rise; ACK-phase falls are told apart by it.
  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    shreg_nx     = shreg;
    sda_oe_nx    = sda_oe;
    reg_addr_nx  = REG_ADDR;
    reg_wdata_nx = REG_WDATA;
    reg_we_nx    = 1'b0;
    reg_re_nx    = 1'b0;
    busy_nx      = BUSY;
    rw_nx        = rw;
    mack_nx      = mack;

    if (start_det) begin
      state_nx   = ST_ADDR;
      bit_cnt_nx = '0;
      sda_oe_nx  = 1'b0;
    end else if (stop_det) begin
      state_nx  = ST_IDLE;
      sda_oe_nx = 1'b0;
      busy_nx   = 1'b0;
    end else begin
      if (REG_RE) begin
        shreg_nx  = REG_RDATA;
        sda_oe_nx = ~REG_RDATA[7];
      end

      if (scl_rise) begin
        case (state)
          ST_ADDR: begin
            shreg_nx   = byte_in;
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (shreg[6:0] == TGT_ADDR) begin
                state_nx = ST_ADDR_ACK;
                rw_nx    = sda_f;
                busy_nx  = 1'b1;
              end else begin
                state_nx = ST_WAIT_STOP;
              end
            end
          end
          ST_PTR: begin
            shreg_nx   = byte_in;
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              reg_addr_nx = byte_in;
              state_nx    = ST_PTR_ACK;
            end
          end
          ST_WDATA: begin
            shreg_nx   = byte_in;
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              reg_wdata_nx = byte_in;
              reg_we_nx    = 1'b1;
              state_nx     = ST_WDATA_ACK;
            end
          end
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: bit_cnt_nx = 4'd9;
          ST_RDATA: begin
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state_nx = ST_RDATA_ACK;
          end
          ST_RDATA_ACK: begin
            bit_cnt_nx = 4'd9;
            mack_nx    = ~sda_f;
            if (!sda_f) reg_addr_nx = REG_ADDR + 8'd1;
          end
          default: ;
        endcase
      end

      if (scl_fall) begin
        case (state)
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nx = 1'b1;
            end else if (bit_cnt == 4'd9) begin
              sda_oe_nx  = 1'b0;
              bit_cnt_nx = '0;
              if (state == ST_ADDR_ACK) begin
                state_nx  = rw ? ST_RDATA : ST_PTR;
                reg_re_nx = rw;
              end else begin
                state_nx = ST_WDATA;
                if (state == ST_WDATA_ACK) reg_addr_nx = REG_ADDR + 8'd1;
              end
            end
          end
          ST_RDATA: begin
            if (bit_cnt != 4'd0) begin
              shreg_nx  = {shreg[6:0], 1'b0};
              sda_oe_nx = ~shreg[6];
            end
          end
          ST_RDATA_ACK: begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nx = 1'b0;
            end else if (bit_cnt == 4'd9) begin
              bit_cnt_nx = '0;
              state_nx   = mack ? ST_RDATA : ST_WAIT_STOP;
              reg_re_nx  = mack;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bus initiator model drives SCL/SDA; a monitor logs REG_WE/REG_RE and target SDA drive.
module tb_i2c_target;

  localparam int Q = 10;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda_bus;
  logic [7:0] REG_ADDR, REG_WDATA, REG_RDATA;
  logic       REG_WE, REG_RE, BUSY;

  pullup (sda_bus);
  assign sda_bus   = m_sda_low ? 1'b0 : 1'bz;
  assign REG_RDATA = REG_ADDR ^ 8'h5A;

  always #5 CLK = ~CLK;

  i2c_target dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .I2C_SCL   (m_scl),
    .I2C_SDA   (sda_bus),
    .REG_ADDR  (REG_ADDR),
    .REG_WDATA (REG_WDATA),
    .REG_WE    (REG_WE),
    .REG_RE    (REG_RE),
    .REG_RDATA (REG_RDATA),
    .BUSY      (BUSY)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int we_cnt = 0, re_cnt = 0, drv_cnt = 0, busy_cnt = 0, clash_cnt = 0;
  logic [7:0] we_addr_log [32];
  logic [7:0] we_data_log [32];
  logic [7:0] re_addr_log [32];

  always @(posedge CLK) begin
    #2;
    if (REG_WE && REG_RE) clash_cnt++;
    if (REG_WE) begin
      we_addr_log[we_cnt % 32] = REG_ADDR;
      we_data_log[we_cnt % 32] = REG_WDATA;
      we_cnt++;
    end
    if (REG_RE) begin
      re_addr_log[re_cnt % 32] = REG_ADDR;
      re_cnt++;
    end
    if (sda_bus === 1'b0 && !m_sda_low) drv_cnt++;
    if (BUSY) busy_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: observed no finish, expected finish before 3ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wq(Q);
    m_scl = 1'b1;     wq(Q);
    m_sda_low = 1'b1; wq(Q);
    m_scl = 1'b0;     wq(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wq(Q);
    m_scl = 1'b1;     wq(Q);
    m_sda_low = 1'b0; wq(Q);
  endtask

  task automatic wr_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda_low = ~b[i]; wq(Q);
      m_scl = 1'b1;      wq(2 * Q);
      m_scl = 1'b0;      wq(Q);
    end
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    wr_bits(b, 8);
    m_sda_low = 1'b0; wq(Q);
    m_scl = 1'b1;     wq(Q);
    ack = (sda_bus === 1'b0);
    wq(Q);
    m_scl = 1'b0;     wq(Q);
  endtask

  task automatic rd_byte(input logic m_ack, output logic [7:0] b);
    m_sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      wq(Q); m_scl = 1'b1;
      wq(Q); b[i] = sda_bus;
      wq(Q); m_scl = 1'b0;
      wq(Q);
    end
    m_sda_low = m_ack; wq(Q);
    m_scl = 1'b1;      wq(2 * Q);
    m_scl = 1'b0;      wq(Q);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;
    int we0, re0, drv0, busy0;

    wq(5);
    chk("rst_reg_addr",  32'(REG_ADDR),  32'h00);
    chk("rst_reg_wdata", 32'(REG_WDATA), 32'h00);
    chk("rst_reg_we",    32'(REG_WE),    32'h0);
    chk("rst_reg_re",    32'(REG_RE),    32'h0);
    chk("rst_busy",      32'(BUSY),      32'h0);
    chk("rst_sda",       32'(sda_bus),   32'h1);
    RESET_N = 1'b1;
    wq(Q);

    // Write: ptr 0x10, data 0xAB, 0xCD
    we0 = we_cnt; re0 = re_cnt;
    i2c_start();
    wr_byte(8'hA0, ack); chk("wr_ack_addr", 32'(ack), 32'h1);
    wr_byte(8'h10, ack); chk("wr_ack_ptr",  32'(ack), 32'h1);
    wr_byte(8'hAB, ack); chk("wr_ack_d0",   32'(ack), 32'h1);
    chk("wr_busy_mid", 32'(BUSY), 32'h1);
    wr_byte(8'hCD, ack); chk("wr_ack_d1",   32'(ack), 32'h1);
    i2c_stop();
    wq(Q);
    chk("wr_busy_after",  32'(BUSY), 32'h0);
    chk("wr_we_count",    32'(we_cnt - we0), 32'd2);
    chk("wr_re_count",    32'(re_cnt - re0), 32'd0);
    chk("wr_we0_addr",    32'(we_addr_log[we0 % 32]), 32'h10);
    chk("wr_we0_data",    32'(we_data_log[we0 % 32]), 32'hAB);
    chk("wr_we1_addr",    32'(we_addr_log[(we0 + 1) % 32]), 32'h11);
    chk("wr_we1_data",    32'(we_data_log[(we0 + 1) % 32]), 32'hCD);

    // Read: ptr 0x20, repeated START, two bytes (ACK then NACK)
    we0 = we_cnt; re0 = re_cnt;
    i2c_start();
    wr_byte(8'hA0, ack); chk("rd_ack_addr_w", 32'(ack), 32'h1);
    wr_byte(8'h20, ack); chk("rd_ack_ptr",    32'(ack), 32'h1);
    i2c_start();
    wr_byte(8'hA1, ack); chk("rd_ack_addr_r", 32'(ack), 32'h1);
    rd_byte(1'b1, rb);   chk("rd_byte0", 32'(rb), 32'h7A);
    rd_byte(1'b0, rb);   chk("rd_byte1", 32'(rb), 32'h7B);
    i2c_stop();
    wq(Q);
    chk("rd_re_count",   32'(re_cnt - re0), 32'd2);
    chk("rd_re0_addr",   32'(re_addr_log[re0 % 32]), 32'h20);
    chk("rd_re1_addr",   32'(re_addr_log[(re0 + 1) % 32]), 32'h21);
    chk("rd_we_count",   32'(we_cnt - we0), 32'd0);
    chk("rd_busy_after", 32'(BUSY), 32'h0);

    // Address mismatch: 0xA2 is address 0x51
    we0 = we_cnt; re0 = re_cnt; drv0 = drv_cnt; busy0 = busy_cnt;
    i2c_start();
    wr_byte(8'hA2, ack); chk("mm_ack_addr", 32'(ack), 32'h0);
    wr_byte(8'h55, ack);
    i2c_stop();
    wq(Q);
    chk("mm_sda_driven", 32'(drv_cnt - drv0),   32'd0);
    chk("mm_we_count",   32'(we_cnt - we0),     32'd0);
    chk("mm_re_count",   32'(re_cnt - re0),     32'd0);
    chk("mm_busy_seen",  32'(busy_cnt - busy0), 32'd0);

    // Pointer wrap 0xFF -> 0x00
    we0 = we_cnt;
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'hFF, ack);
    wr_byte(8'h11, ack);
    wr_byte(8'h22, ack);
    i2c_stop();
    wq(Q);
    chk("wrap_we_count", 32'(we_cnt - we0), 32'd2);
    chk("wrap_we0_addr", 32'(we_addr_log[we0 % 32]), 32'hFF);
    chk("wrap_we0_data", 32'(we_data_log[we0 % 32]), 32'h11);
    chk("wrap_we1_addr", 32'(we_addr_log[(we0 + 1) % 32]), 32'h00);
    chk("wrap_we1_data", 32'(we_data_log[(we0 + 1) % 32]), 32'h22);
    chk("wrap_ptr_end",  32'(REG_ADDR), 32'h01);

    // Abort: STOP after 4 data bits, then reset during an address ACK
    we0 = we_cnt;
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h30, ack);
    wr_bits(8'h9F, 4);
    i2c_stop();
    wq(Q);
    chk("abort_we_count", 32'(we_cnt - we0), 32'd0);
    i2c_start();
    wr_bits(8'hA0, 8);
    m_sda_low = 1'b0;
    wq(Q);
    chk("abort_ack_drv", 32'(sda_bus), 32'h0);
    RESET_N = 1'b0;
    #1;
    chk("abort_sda_rel",   32'(sda_bus),   32'h1);
    chk("abort_reg_addr",  32'(REG_ADDR),  32'h00);
    chk("abort_reg_wdata", 32'(REG_WDATA), 32'h00);
    chk("abort_busy",      32'(BUSY),      32'h0);
    chk("abort_we",        32'(REG_WE),    32'h0);
    chk("abort_re",        32'(REG_RE),    32'h0);
    wq(3);
    RESET_N = 1'b1;
    wq(Q);
    m_scl = 1'b1;
    wq(Q);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // 2-CLK SDA low pulse with SCL high must be filtered out
    m_sda_low = 1'b1;
    wq(2);
    m_sda_low = 1'b0;
    wq(20);
    chk("glitch_state_idle", 32'(dut.state), 32'h0);
`endif

    chk("we_re_clash", 32'(clash_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
